// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem read, IF/ID register plus one skid
// entry for a response that lands while decode is stalled.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_inst,
    output logic [5:0]  ifid_op,
    output logic [5:0]  ifid_func,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        halted
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_BUF, S_HALT} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } entry_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_drop;
    logic        r_halted;
    logic        r_ifid_valid;
    entry_t      r_ifid;
    logic        r_skid_valid;
    entry_t      r_skid;

    logic        w_ifid_free;
    entry_t      w_fetched;
    logic        w_rdata_halt;
    logic        w_skid_halt;

    assign w_ifid_free  = !r_ifid_valid || !stall;
    assign w_fetched    = {imem_rdata, r_pc, r_pc + 32'd4};
    assign w_rdata_halt = (imem_rdata == HALT_INST);
    assign w_skid_halt  = (r_skid.inst == HALT_INST);

    // Gated by rst so no request is seen while reset is held, yet the first
    // post-reset cycle already issues the fetch at RESET_PC.
    assign imem_req  = (r_state == S_REQ) && !rst;
    assign imem_addr = r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_drop       <= 1'b0;
            r_halted     <= 1'b0;
            r_ifid_valid <= 1'b0;
            r_ifid       <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else begin
            // Decode consumes on valid && !stall; a load below overrides this.
            if (r_ifid_valid && !stall)
                r_ifid_valid <= 1'b0;

            if (redirect) begin
                r_pc         <= redirect_pc;
                r_ifid_valid <= 1'b0;
                r_skid_valid <= 1'b0;
                r_halted     <= 1'b0;
                if (r_state == S_WAIT && !imem_ack) begin
                    r_drop <= 1'b1;
                end else begin
                    r_drop  <= 1'b0;
                    r_state <= S_REQ;
                end
            end else begin
                case (r_state)
                    S_REQ: r_state <= S_WAIT;
                    S_WAIT: begin
                        if (imem_ack) begin
                            if (r_drop) begin
                                r_drop  <= 1'b0;
                                r_state <= S_REQ;
                            end else begin
                                r_pc <= r_pc + 32'd4;
                                if (w_ifid_free) begin
                                    r_ifid       <= w_fetched;
                                    r_ifid_valid <= 1'b1;
                                    if (w_rdata_halt) begin
                                        r_halted <= 1'b1;
                                        r_state  <= S_HALT;
                                    end else begin
                                        r_state  <= S_REQ;
                                    end
                                end else begin
                                    r_skid       <= w_fetched;
                                    r_skid_valid <= 1'b1;
                                    r_state      <= S_BUF;
                                end
                            end
                        end
                    end
                    S_BUF: begin
                        if (!stall && r_skid_valid) begin
                            r_ifid       <= r_skid;
                            r_ifid_valid <= 1'b1;
                            r_skid_valid <= 1'b0;
                            if (w_skid_halt) begin
                                r_halted <= 1'b1;
                                r_state  <= S_HALT;
                            end else begin
                                r_state  <= S_REQ;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ifid_valid = r_ifid_valid;
    assign ifid_inst  = r_ifid.inst;
    assign ifid_op    = r_ifid.inst[31:26];
    assign ifid_func  = r_ifid.inst[5:0];
    assign ifid_pc    = r_ifid.pc;
    assign ifid_pc4   = r_ifid.pc4;
    assign halted     = r_halted;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed fetch scenarios followed by randomized traffic against a
// queue-based reference model of the fetch stage.
module tb_instruction_fetch_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_inst;
    logic [5:0]  ifid_op;
    logic [5:0]  ifid_func;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        halted;

    int total = 0;
    int bad   = 0;

    instruction_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_valid(ifid_valid), .ifid_inst(ifid_inst),
        .ifid_op(ifid_op), .ifid_func(ifid_func),
        .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: queue of fetched-but-not-consumed words (IF/ID first).
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_out, m_drop, m_halt_seen;
    bit          mem_pend;
    int          mem_cnt;

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", ifid_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc4", ifid_pc4, 0);
        rst = 1'b0;
        #1;
        chk("c0_req", imem_req, 1);
        chk("c0_addr", imem_addr, 0);
        @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        @(negedge clk); imem_ack = 1'b0;
        chk("c2_valid", ifid_valid, 1);
        chk("c2_op", ifid_op, 6'h08);
        chk("c2_pc", ifid_pc, 0);
        chk("c2_pc4", ifid_pc4, 4);
        chk("c2_addr", imem_addr, 4);
        stall = 1'b1;
        @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'h0085_1020;
        @(negedge clk); imem_ack = 1'b0;
        chk("buf_hold_inst", ifid_inst, 32'h2008_0005);
        chk("buf_noreq", imem_req, 0);
        @(negedge clk);
        chk("buf_noreq2", imem_req, 0);
        stall = 1'b0;
        @(negedge clk);
        chk("skid_func", ifid_func, 6'h20);
        chk("skid_pc", ifid_pc, 4);
        chk("skid_req", imem_req, 1);
        chk("skid_addr", imem_addr, 8);
        @(negedge clk);
        chk("consumed", ifid_valid, 0);
        redirect = 1'b1; redirect_pc = 32'h40;
        @(negedge clk); redirect = 1'b0;
        chk("drop_wait_valid", ifid_valid, 0);
        @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk); imem_ack = 1'b0;
        chk("drop_valid", ifid_valid, 0);
        chk("drop_addr", imem_addr, 32'h40);
        chk("drop_req", imem_req, 1);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_0000; redirect = 1'b1; redirect_pc = 32'h10;
        @(negedge clk); imem_ack = 1'b0; redirect = 1'b0;
        chk("redir_ack_valid", ifid_valid, 0);
        chk("redir_ack_addr", imem_addr, 32'h10);
        chk("redir_ack_req", imem_req, 1);
        @(negedge clk); imem_ack = 1'b1; imem_rdata = HALT;
        @(negedge clk); imem_ack = 1'b0;
        chk("halt_flag", halted, 1);
        chk("halt_pc", ifid_pc, 32'h10);
        repeat (3) @(negedge clk);
        chk("halt_noreq", imem_req, 0);
        redirect = 1'b1; redirect_pc = 32'h20;
        @(negedge clk); redirect = 1'b0;
        chk("unhalt_flag", halted, 0);
        chk("unhalt_addr", imem_addr, 32'h20);
        chk("unhalt_req", imem_req, 1);
        @(negedge clk);
        stall = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_req", imem_req, 0);
        chk("async_pc", ifid_pc, 0);
        chk("async_inst", ifid_inst, 0);
        chk("async_addr", imem_addr, 0);
        @(negedge clk); rst = 1'b0; stall = 1'b0;
        #1;

        // Randomized phase, model starts from reset state.
        q.delete();
        m_pc = 32'h0; m_out = 0; m_drop = 0; m_halt_seen = 0;
        mem_pend = 0; mem_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          exp_req, out_before, dut_req;
            logic [31:0] e_inst;
            exp_req = !m_out && !m_halt_seen && (q.size() < 2);
            chk("req", imem_req, exp_req);
            if (exp_req) chk("addr", imem_addr, m_pc);
            chk("valid", ifid_valid, q.size() > 0);
            if (q.size() > 0) begin
                e_inst = q[0].inst;
                chk("inst", ifid_inst, e_inst);
                chk("op", ifid_op, e_inst[31:26]);
                chk("func", ifid_func, e_inst[5:0]);
                chk("pc", ifid_pc, q[0].pc);
                chk("pc4", ifid_pc4, q[0].pc + 32'd4);
            end
            chk("halted", halted, m_halt_seen && q.size() < 2);

            imem_ack = 1'b0;
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_ack = 1'b1;
                    mem_pend = 0;
                    case ($urandom % 16)
                        0:       imem_rdata = HALT;
                        1:       imem_rdata = 32'h0;
                        default: imem_rdata = $urandom;
                    endcase
                end
            end
            stall    = ($urandom % 3) == 0;
            redirect = ($urandom % 25) == 0;
            case ($urandom % 4)
                0:       redirect_pc = 32'hFFFF_FFF8;
                1:       redirect_pc = $urandom;
                default: redirect_pc = $urandom & 32'hFFFF_FFFC;
            endcase
            dut_req = imem_req;
            if (dut_req && !redirect) begin
                mem_pend = 1;
                mem_cnt  = 1 + ($urandom % 3);
            end

            out_before = m_out;
            if (redirect) begin
                q.delete();
                m_pc        = redirect_pc;
                m_halt_seen = 0;
                m_out       = out_before && !imem_ack;
                m_drop      = m_out;
            end else begin
                if (!stall && q.size() > 0) void'(q.pop_front());
                if (imem_ack && out_before) begin
                    m_out = 0;
                    if (m_drop) begin
                        m_drop = 0;
                    end else begin
                        q.push_back('{inst: imem_rdata, pc: m_pc});
                        m_pc = m_pc + 32'd4;
                        if (imem_rdata == HALT) m_halt_seen = 1;
                    end
                end
                if (exp_req) m_out = 1;
            end
            @(negedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
